// File: rtl/pulse_width_monitor_if.sv
// ============================================================================
// pulse_width_monitor_if : control, monitored-signal and result bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface pulse_width_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
);
  logic              en;
  logic [CNT_W-1:0]  min_len;
  logic [CNT_W-1:0]  max_len;
  logic [NUM_CH-1:0] sig_in;
  logic              err_clr;
  logic              stat_clr;
  logic [NUM_CH-1:0] pass_pulse;
  logic [NUM_CH-1:0] short_err;
  logic [NUM_CH-1:0] long_err;
  logic [NUM_CH-1:0] err_sticky;
  logic [STAT_W-1:0] pass_cnt;
  logic [STAT_W-1:0] fail_cnt;

  modport master (
    output en, min_len, max_len, sig_in, err_clr, stat_clr,
    input  pass_pulse, short_err, long_err, err_sticky, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, min_len, max_len, sig_in, err_clr, stat_clr,
    output pass_pulse, short_err, long_err, err_sticky, pass_cnt, fail_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pulse_width_monitor.sv
// ============================================================================
// pulse_width_monitor : per-channel pulse length classifier with sticky
// error flags and saturating pass/fail statistics.  Rev 1.0
// ============================================================================
`default_nettype none

module pulse_width_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pulse_width_monitor_if.slave   bus
);

  localparam int c_PC_W = $clog2(NUM_CH + 1) + 1;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2,
    OVER     = 2'd3
  } state_t;

  logic [NUM_CH-1:0] w_pass_str;
  logic [NUM_CH-1:0] w_short_str;
  logic [NUM_CH-1:0] w_long_str;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_lim_min, w_lim_min_nxt;
    logic [CNT_W-1:0] r_lim_max, w_lim_max_nxt;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_pass, w_short, w_long;
    logic             r_pass, r_short, r_long;

    // One extra bit so an all-ones count against an all-ones limit cannot wrap
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_lim_min_nxt = r_lim_min;
      w_lim_max_nxt = r_lim_max;
      w_pass        = 1'b0;
      w_short       = 1'b0;
      w_long        = 1'b0;
      if (!bus.en) begin
        w_state_nxt = WAIT_LOW;
      end else begin
        case (r_state)
          WAIT_LOW: begin
            if (!bus.sig_in[i]) w_state_nxt = IDLE;
          end
          IDLE: begin
            if (bus.sig_in[i]) begin
              w_state_nxt   = HIGH;
              w_cnt_nxt     = {{(CNT_W-1){1'b0}}, 1'b1};
              w_lim_min_nxt = (bus.min_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                                  : bus.min_len;
              w_lim_max_nxt = bus.max_len;
            end
          end
          HIGH: begin
            if (bus.sig_in[i]) begin
              if (w_cnt_inc > {1'b0, r_lim_max}) begin
                w_long      = 1'b1;
                w_state_nxt = OVER;
              end else begin
                w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
              end
            end else begin
              if (r_cnt < r_lim_min) w_short = 1'b1;
              else                   w_pass  = 1'b1;
              w_state_nxt = IDLE;
            end
          end
          OVER: begin
            if (!bus.sig_in[i]) w_state_nxt = IDLE;
          end
          default: w_state_nxt = WAIT_LOW;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= WAIT_LOW;
        r_cnt     <= '0;
        r_lim_min <= '0;
        r_lim_max <= '0;
        r_pass    <= 1'b0;
        r_short   <= 1'b0;
        r_long    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_lim_min <= w_lim_min_nxt;
        r_lim_max <= w_lim_max_nxt;
        r_pass    <= w_pass;
        r_short   <= w_short;
        r_long    <= w_long;
      end
    end

    assign w_pass_str[i]  = r_pass;
    assign w_short_str[i] = r_short;
    assign w_long_str[i]  = r_long;
  end

  function automatic logic [c_PC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [c_PC_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      n = n + {{(c_PC_W-1){1'b0}}, v[k]};
    end
    return n;
  endfunction

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] base,
                                                 input logic [c_PC_W-1:0] inc);
    logic [STAT_W+c_PC_W-1:0] sum;
    sum = {{c_PC_W{1'b0}}, base} + {{STAT_W{1'b0}}, inc};
    if (sum > {{c_PC_W{1'b0}}, {STAT_W{1'b1}}}) return {STAT_W{1'b1}};
    return sum[STAT_W-1:0];
  endfunction

  logic [NUM_CH-1:0] r_sticky;
  logic [STAT_W-1:0] r_pass_cnt;
  logic [STAT_W-1:0] r_fail_cnt;
  logic [STAT_W-1:0] w_pass_base;
  logic [STAT_W-1:0] w_fail_base;
  logic [NUM_CH-1:0] w_err_str;

  assign w_err_str   = w_short_str | w_long_str;
  // Clearing and counting in one cycle leaves only that cycle's events
  assign w_pass_base = bus.stat_clr ? '0 : r_pass_cnt;
  assign w_fail_base = bus.stat_clr ? '0 : r_fail_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky   <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_sticky   <= (r_sticky & ~{NUM_CH{bus.err_clr}}) | w_err_str;
      r_pass_cnt <= sat_add(w_pass_base, popcount(w_pass_str));
      r_fail_cnt <= sat_add(w_fail_base, popcount(w_err_str));
    end
  end

  assign bus.pass_pulse = w_pass_str;
  assign bus.short_err  = w_short_str;
  assign bus.long_err   = w_long_str;
  assign bus.err_sticky = r_sticky;
  assign bus.pass_cnt   = r_pass_cnt;
  assign bus.fail_cnt   = r_fail_cnt;

endmodule

`default_nettype wire
